// File: rtl/riscv_test_monitor_pkg.sv
// Shared definitions for the riscv-tests end-of-test monitor:
// per-hart state encodings and monitoring mode selectors.
package riscv_test_monitor_pkg;

    // Per-hart FSM encodings (3 bits, kept as plain constants for legacy tools)
    localparam logic [2:0] TM_IDLE    = 3'd0;
    localparam logic [2:0] TM_RUN     = 3'd1;
    localparam logic [2:0] TM_DRAIN   = 3'd2;
    localparam logic [2:0] TM_PASS    = 3'd3;
    localparam logic [2:0] TM_FAIL    = 3'd4;
    localparam logic [2:0] TM_TIMEOUT = 3'd5;

    // End-of-test detection modes
    localparam int TM_MODE_PC     = 0;  // fetch PC reaches DONE_PC, then check gp
    localparam int TM_MODE_TOHOST = 1;  // non-zero store to TOHOST_ADDR

endpackage

// File: rtl/riscv_test_monitor_hart.sv
// One hart's end-of-test FSM: detects completion (PC match + drained gp
// sample, or a tohost store), latches the verdict and the failing test number.
module riscv_test_monitor_hart
    import riscv_test_monitor_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              MODE        = TM_MODE_PC,
    parameter logic [XLEN-1:0] DONE_PC     = 'h44,
    parameter int              SETTLE      = 4,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 'h1000,
    parameter int              CODE_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              tmo_i,
    input  logic              pc_valid_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   gp_i,
    input  logic              st_valid_i,
    input  logic [XLEN-1:0]   st_addr_i,
    input  logic [XLEN-1:0]   st_data_i,
    output logic              done_o,
    output logic              pass_o,
    output logic              active_o,
    output logic [CODE_W-1:0] fail_code_o
);

    logic [2:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              judge;
    logic [XLEN-1:0]   result;

    // Next-state logic: start overrides everything, completion beats timeout
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        judge   = 1'b0;
        result  = gp_i;

        if (start_i) begin
            state_d = TM_RUN;
            cnt_d   = '0;
            code_d  = '0;
        end else begin
            case (state_q)
                TM_RUN: begin
                    if (MODE == TM_MODE_PC) begin
                        if (pc_valid_i && (pc_i == DONE_PC)) begin
                            if (SETTLE == 0) begin
                                judge = 1'b1;
                            end else begin
                                state_d = TM_DRAIN;
                                cnt_d   = 8'(SETTLE);
                            end
                        end else if (tmo_i) begin
                            state_d = TM_TIMEOUT;
                        end
                    end else begin
                        result = st_data_i;
                        if (st_valid_i && (st_addr_i == TOHOST_ADDR) && (st_data_i != '0)) begin
                            judge = 1'b1;
                        end else if (tmo_i) begin
                            state_d = TM_TIMEOUT;
                        end
                    end
                end
                TM_DRAIN: begin
                    // Pipeline drain: pc/gp activity is ignored until the sample cycle
                    if (cnt_q == 8'd1) begin
                        judge = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                        if (tmo_i) begin
                            state_d = TM_TIMEOUT;
                        end
                    end
                end
                default: ;
            endcase

            // riscv-tests convention: value 1 = pass, otherwise (test_num << 1) | 1
            if (judge) begin
                if (result == XLEN'(1)) begin
                    state_d = TM_PASS;
                end else begin
                    state_d = TM_FAIL;
                    code_d  = result[CODE_W:1];
                end
            end
        end
    end

    // State, drain counter and fail code registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TM_IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    assign done_o      = (state_q == TM_PASS) || (state_q == TM_FAIL) || (state_q == TM_TIMEOUT);
    assign pass_o      = (state_q == TM_PASS);
    assign active_o    = (state_q == TM_RUN) || (state_q == TM_DRAIN);
    assign fail_code_o = code_q;

endmodule

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor for riscv-tests runs: one FSM per hart plus a shared
// cycle watchdog and the all_done/all_pass summary.
module riscv_test_monitor
    import riscv_test_monitor_pkg::*;
#(
    parameter int              NUM_HARTS   = 1,
    parameter int              XLEN        = 32,
    parameter int              MODE        = TM_MODE_PC,
    parameter logic [XLEN-1:0] DONE_PC     = 32'h44,
    parameter int              SETTLE      = 4,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h1000,
    parameter int              TIMEOUT     = 6000,
    parameter int              CODE_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NUM_HARTS-1:0]          pc_valid,
    input  logic [NUM_HARTS*XLEN-1:0]     pc,
    input  logic [NUM_HARTS*XLEN-1:0]     gp,
    input  logic [NUM_HARTS-1:0]          st_valid,
    input  logic [NUM_HARTS*XLEN-1:0]     st_addr,
    input  logic [NUM_HARTS*XLEN-1:0]     st_data,
    output logic [NUM_HARTS-1:0]          done,
    output logic [NUM_HARTS-1:0]          pass,
    output logic [NUM_HARTS*CODE_W-1:0]   fail_code,
    output logic                          all_done,
    output logic                          all_pass,
    output logic                          timed_out,
    output logic [$clog2(TIMEOUT+1)-1:0]  cycles
);

    localparam int            CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LIM = CW'(TIMEOUT);
    localparam logic [CW-1:0] TMO_M1  = CW'(TIMEOUT - 1);

    logic [NUM_HARTS-1:0] active;
    logic                 any_active;
    logic                 tmo_fire;
    logic [CW-1:0]        cycles_q, cycles_d;
    logic                 timed_out_q, timed_out_d;

    assign any_active = |active;
    // Fires on the edge where the counter lands on TIMEOUT
    assign tmo_fire   = any_active && (cycles_q >= TMO_M1);

    // Watchdog: count while any hart is running, saturate at TIMEOUT
    always_comb begin
        cycles_d    = cycles_q;
        timed_out_d = timed_out_q;
        if (start) begin
            cycles_d    = '0;
            timed_out_d = 1'b0;
        end else if (any_active) begin
            if (cycles_q != TMO_LIM) begin
                cycles_d = cycles_q + CW'(1);
            end
            if (tmo_fire) begin
                timed_out_d = 1'b1;
            end
        end
    end

    // Watchdog registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles_q    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            cycles_q    <= cycles_d;
            timed_out_q <= timed_out_d;
        end
    end

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        riscv_test_monitor_hart #(
            .XLEN        (XLEN),
            .MODE        (MODE),
            .DONE_PC     (DONE_PC),
            .SETTLE      (SETTLE),
            .TOHOST_ADDR (TOHOST_ADDR),
            .CODE_W      (CODE_W)
        ) u_hart (
            .clk         (clk),
            .rst_n       (rst_n),
            .start_i     (start),
            .tmo_i       (tmo_fire),
            .pc_valid_i  (pc_valid[h]),
            .pc_i        (pc[h*XLEN +: XLEN]),
            .gp_i        (gp[h*XLEN +: XLEN]),
            .st_valid_i  (st_valid[h]),
            .st_addr_i   (st_addr[h*XLEN +: XLEN]),
            .st_data_i   (st_data[h*XLEN +: XLEN]),
            .done_o      (done[h]),
            .pass_o      (pass[h]),
            .active_o    (active[h]),
            .fail_code_o (fail_code[h*CODE_W +: CODE_W])
        );
    end

    assign all_done  = &done;
    assign all_pass  = &pass;
    assign timed_out = timed_out_q;
    assign cycles    = cycles_q;

endmodule
